// File: rtl/hazard_ctrl_sb_if.sv
// Pipeline <-> hazard unit bundle: ID/EX/WB status in, stage enables/flushes out.
// master = pipeline side, slave = hazard_ctrl_sb.
interface hazard_ctrl_sb_if #(
   parameter int REG_AW          = 5,
   parameter int MAX_OUTSTANDING = 2
);
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);

   logic              id_valid;
   logic [REG_AW-1:0] id_rs1;
   logic [REG_AW-1:0] id_rs2;
   logic              id_use_rs1;
   logic              id_use_rs2;
   logic              id_mem_read;
   logic              ex_valid;
   logic              ex_mem_read;
   logic [REG_AW-1:0] ex_rd;
   logic              ex_branch_taken;
   logic              wb_ld_valid;
   logic [REG_AW-1:0] wb_ld_rd;
   logic              mem_busy;
   logic              pc_write;
   logic              if_id_write;
   logic              id_ex_bubble;
   logic              if_id_flush;
   logic              id_ex_flush;
   logic              ex_mem_write;
   logic [CW-1:0]     pending_cnt;

   modport master (
      output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_mem_read,
             ex_valid, ex_mem_read, ex_rd, ex_branch_taken,
             wb_ld_valid, wb_ld_rd, mem_busy,
      input  pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush,
             ex_mem_write, pending_cnt
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_mem_read,
             ex_valid, ex_mem_read, ex_rd, ex_branch_taken,
             wb_ld_valid, wb_ld_rd, mem_busy,
      output pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush,
             ex_mem_write, pending_cnt
   );
endinterface

// File: rtl/hazard_ctrl_sb.sv
// Scoreboard hazard / pipeline control for the 5-stage core.
// Tracks in-flight loads, sequences multi-cycle branch flushes and freezes
// the pipe while data memory is busy.
// Optional: define HAZARD_PERF_CNT_EN to add stall/flush/freeze cycle counters.
module hazard_ctrl_sb #(
   parameter int REG_AW          = 5,
   parameter int MAX_OUTSTANDING = 2,
   parameter int FLUSH_CYCLES    = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   hazard_ctrl_sb_if.slave   bus
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]       stall_cycles,
   output logic [31:0]       flush_cycles,
   output logic [31:0]       freeze_cycles
`endif
);
   localparam int         NREG  = 2 ** REG_AW;
   localparam int         CW    = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [2:0] FLOAD = 3'(FLUSH_CYCLES - 1);

   typedef enum logic [1:0] {RUN, FLUSH, FREEZE} state_t;

   state_t          state, state_nxt, eff;
   logic [2:0]      fcnt, fcnt_nxt;
   logic [NREG-1:0] pend, pend_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic            ld_issue, wb_hit, ex_ld;
   logic            hit1, hit2, raw_hit, cap_hit, stall, flush;
   logic [CW:0]     inflight;

   // Mode in force this cycle: busy memory freezes at once, and the first
   // non-busy cycle after a freeze already behaves as the resumed mode.
   always_comb begin
      eff = state;
      if (bus.mem_busy)          eff = FREEZE;
      else if (state == FREEZE)  eff = (fcnt != 3'd0) ? FLUSH : RUN;
   end

   // Hazard detection: EX load forwarding gap, scoreboard hits, load capacity.
   always_comb begin
      ex_ld    = bus.ex_valid & bus.ex_mem_read;
      ld_issue = ex_ld & (bus.ex_rd != '0) & (eff != FREEZE);
      wb_hit   = bus.wb_ld_valid & pend[bus.wb_ld_rd];
      hit1     = bus.id_use_rs1 & (bus.id_rs1 != '0) &
                 ((ex_ld & (bus.ex_rd == bus.id_rs1)) | pend[bus.id_rs1]);
      hit2     = bus.id_use_rs2 & (bus.id_rs2 != '0) &
                 ((ex_ld & (bus.ex_rd == bus.id_rs2)) | pend[bus.id_rs2]);
      raw_hit  = hit1 | hit2;
      inflight = {1'b0, cnt} + {{CW{1'b0}}, ld_issue};
      cap_hit  = bus.id_valid & bus.id_mem_read &
                 (inflight >= (CW+1)'(MAX_OUTSTANDING));
      stall    = bus.id_valid & (raw_hit | cap_hit);
   end

   // Scoreboard update: issue sets after writeback clears, so a same-register
   // reissue keeps the bit; writebacks to idle registers are ignored.
   always_comb begin
      pend_nxt = pend;
      if (wb_hit)   pend_nxt[bus.wb_ld_rd] = 1'b0;
      if (ld_issue) pend_nxt[bus.ex_rd]    = 1'b1;
      pend_nxt[0] = 1'b0;
      cnt_nxt = cnt;
      if (ld_issue && !wb_hit && cnt != CW'(MAX_OUTSTANDING))
         cnt_nxt = cnt + CW'(1);
      else if (wb_hit && !ld_issue && cnt != '0)
         cnt_nxt = cnt - CW'(1);
   end

   // FSM next state: a taken branch (re)starts the flush window; a freeze
   // holds fcnt so the remaining flush cycles resume afterwards.
   always_comb begin
      state_nxt = state;
      fcnt_nxt  = fcnt;
      flush     = 1'b0;
      if (eff == FREEZE) begin
         state_nxt = FREEZE;
      end else begin
         if (bus.ex_branch_taken) begin
            flush    = 1'b1;
            fcnt_nxt = FLOAD;
         end else if (eff == FLUSH) begin
            flush    = 1'b1;
            fcnt_nxt = fcnt - 3'd1;
         end
         state_nxt = (fcnt_nxt != 3'd0) ? FLUSH : RUN;
      end
   end

   // Stage controls: freeze > flush > stall; reset forces the idle pattern.
   always_comb begin
      bus.pc_write     = 1'b1;
      bus.if_id_write  = 1'b1;
      bus.ex_mem_write = 1'b1;
      bus.id_ex_bubble = 1'b0;
      bus.if_id_flush  = 1'b0;
      bus.id_ex_flush  = 1'b0;
      if (rst_n) begin
         if (eff == FREEZE) begin
            bus.pc_write     = 1'b0;
            bus.if_id_write  = 1'b0;
            bus.ex_mem_write = 1'b0;
         end else if (flush) begin
            bus.if_id_flush  = 1'b1;
            bus.id_ex_flush  = 1'b1;
         end else if (stall) begin
            bus.pc_write     = 1'b0;
            bus.if_id_write  = 1'b0;
            bus.id_ex_bubble = 1'b1;
         end
      end
   end

   assign bus.pending_cnt = cnt;

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
         fcnt  <= 3'd0;
         pend  <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         fcnt  <= fcnt_nxt;
         pend  <= pend_nxt;
         cnt   <= cnt_nxt;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   // Free-running event counters, wrapping at 2**32.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles  <= '0;
         flush_cycles  <= '0;
         freeze_cycles <= '0;
      end else begin
         if (bus.id_ex_bubble) stall_cycles  <= stall_cycles + 32'd1;
         if (bus.if_id_flush)  flush_cycles  <= flush_cycles + 32'd1;
         if (eff == FREEZE)    freeze_cycles <= freeze_cycles + 32'd1;
      end
   end
`endif
endmodule
